// File: rtl/score_pkg.sv
// Shared types and defaults for the score display controller.
// Holds the FSM encoding, the default sizes and the double-dabble nibble adjust.
package score_pkg;

    localparam int DEF_SCORE_W   = 14;
    localparam int DEF_AMT_W     = 8;
    localparam int DEF_NDIG      = 4;
    localparam int DEF_MAX_SCORE = 9999;
    localparam int NIB_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CONV  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // A nibble of 5 or more would exceed 9 after the next doubling.
    function automatic logic [NIB_W-1:0] dabble_adjust(input logic [NIB_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock.
// done is high during the final step, so bcd is complete on the following cycle.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int NDIG    = DEF_NDIG
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SCORE_W-1:0]       bin,
    output logic [NDIG*NIB_W-1:0]    bcd,
    output logic                     done
);

    localparam int BCD_W = NDIG * NIB_W;
    localparam int CNT_W = $clog2(SCORE_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);

    logic [SCORE_W-1:0] shifter;
    logic [CNT_W-1:0]   step;
    logic               running;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   bcd_next;
    logic [SCORE_W-1:0] shifter_next;
    logic               shift_unused;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        adjusted = bcd;
        for (int i = 0; i < NDIG; i++) begin
            adjusted[i*NIB_W +: NIB_W] = dabble_adjust(bcd[i*NIB_W +: NIB_W]);
        end
        {shift_unused, bcd_next, shifter_next} = {adjusted, shifter, 1'b0};
    end

    assign done = running && (step == LAST_STEP);

    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with <= so every register samples pre-edge values.
        if (!reset) begin
            shifter <= '0;
            bcd     <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            shifter <= bin;
            bcd     <= '0;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            bcd     <= bcd_next;
            shifter <= shifter_next;
            step    <= step + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score owner: round-robin arbiter for two add requesters, saturating adder,
// and the FSM that drives a sequential BCD conversion into stable display digits.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int AMT_W     = DEF_AMT_W,
    parameter int NDIG      = DEF_NDIG,
    parameter int MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req_a,
    input  logic [AMT_W-1:0]      amt_a,
    output logic                  ack_a,
    input  logic                  req_b,
    input  logic [AMT_W-1:0]      amt_b,
    output logic                  ack_b,
    output logic [4*NDIG-1:0]     digits,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam logic [SCORE_W:0]   MAX_SUM = (SCORE_W + 1)'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    state_t             state;
    logic [SCORE_W-1:0] score;
    logic [AMT_W-1:0]   amount;
    logic               rr_b;
    logic [SCORE_W:0]   sum;
    logic               saturate;
    logic [SCORE_W-1:0] next_score;
    logic               grant_a;
    logic               grant_b;
    logic               conv_start;
    logic               conv_done;
    logic [4*NDIG-1:0]  conv_bcd;

    // rr_b names the side that wins the next contended cycle.
    assign grant_a = req_a && (!req_b || !rr_b);
    assign grant_b = req_b && (!req_a || rr_b);

    assign sum        = {1'b0, score} + (SCORE_W + 1)'(amount);
    assign saturate   = sum > MAX_SUM;
    assign next_score = saturate ? MAX_VAL : sum[SCORE_W-1:0];
    assign conv_start = (state == ADD) && !clear;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .NDIG    (NDIG)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .abort (clear),
        .bin   (next_score),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            score     <= '0;
            amount    <= '0;
            rr_b      <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            digits    <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            score     <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            digits    <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            bcd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        amount <= grant_a ? amt_a : amt_b;
                        ack_a  <= grant_a;
                        ack_b  <= grant_b;
                        if (req_a && req_b) begin
                            rr_b <= grant_a;
                        end
                        busy   <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    score <= next_score;
                    if (saturate) begin
                        overflow <= 1'b1;
                    end
                    state <= CONV;
                end
                CONV: begin
                    if (conv_done) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    digits    <= conv_bcd;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed and randomized bench for score_display_ctrl against a decimal
// reference model of score, overflow, round-robin pointer and displayed digits.
module tb_score_display_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        req_a = 1'b0;
    logic [7:0]  amt_a = '0;
    logic        ack_a;
    logic        req_b = 1'b0;
    logic [7:0]  amt_b = '0;
    logic        ack_b;
    logic [15:0] digits;
    logic        bcd_valid;
    logic        busy;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;

    int          score_m  = 0;
    bit          ovf_m    = 1'b0;
    bit          rr_m     = 1'b0;
    logic [15:0] digits_m = '0;

    score_display_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .req_a     (req_a),
        .amt_a     (amt_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .amt_b     (amt_b),
        .ack_b     (ack_b),
        .digits    (digits),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        int          v;
        v = value;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack_a"}, ack_a, 0);
        check({tag, "_ack_b"}, ack_b, 0);
        check({tag, "_digits"}, digits, digits_m);
        check({tag, "_valid"}, bcd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, overflow, ovf_m);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        score_m  = 0;
        ovf_m    = 1'b0;
        rr_m     = 1'b0;
        digits_m = '0;
        check_idle_outputs("reset");
        reset = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear    = 1'b0;
        score_m  = 0;
        ovf_m    = 1'b0;
        digits_m = '0;
        check_idle_outputs("clear");
    endtask

    // Called on a negedge with the DUT idle; returns 0 for an A grant, 1 for B.
    task automatic grant(input bit ra, input bit rb, input int aa, input int ab, output bit g);
        req_a = ra;
        req_b = rb;
        amt_a = 8'(aa);
        amt_b = 8'(ab);
        g = (ra && rb) ? rr_m : !ra;
        if (ra && rb) rr_m = !g;
        @(negedge clock);
        check("grant_ack_a", ack_a, !g);
        check("grant_ack_b", ack_b, g);
        check("grant_busy", busy, 1);
        if (g) req_b = 1'b0;
        else   req_a = 1'b0;
        score_m = score_m + (g ? ab : aa);
        if (score_m > 9999) begin
            score_m = 9999;
            ovf_m   = 1'b1;
        end
    endtask

    task automatic wait_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("hold_digits", digits, digits_m);
            check("hold_valid", bcd_valid, 0);
            check("hold_busy", busy, 1);
        end
    endtask

    task automatic finish_conv();
        wait_hold(15);
        @(negedge clock);
        digits_m = to_bcd(score_m);
        check("latch_valid", bcd_valid, 1);
        check("latch_digits", digits, digits_m);
        check("latch_busy", busy, 0);
        check("latch_ovf", overflow, ovf_m);
    endtask

    task automatic add(input bit ra, input bit rb, input int aa, input int ab);
        bit g;
        grant(ra, rb, aa, ab, g);
        finish_conv();
    endtask

    initial begin
        bit g;
        bit order [4];
        int p;

        do_reset();

        // Single uncontended add.
        grant(1'b1, 1'b0, 37, 0, g);
        finish_conv();
        check("single_37", digits, 16'h0037);

        // Contended round-robin from score 0.
        do_clear();
        for (int i = 0; i < 4; i++) begin
            grant(1'b1, 1'b1, 10, 200, g);
            order[i] = g;
            finish_conv();
        end
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 0);
        check("rr_order3", order[3], 1);
        check("rr_total", digits, 16'h0420);

        // Saturation at the ceiling.
        do_clear();
        for (int i = 0; i < 49; i++) add(1'b1, 1'b0, 200, 0);
        add(1'b0, 1'b1, 0, 150);
        check("preload_9950", digits, 16'h9950);
        add(1'b1, 1'b0, 100, 0);
        check("sat_digits", digits, 16'h9999);
        check("sat_ovf", overflow, 1);
        add(1'b0, 1'b1, 0, 5);
        check("sat_hold", digits, 16'h9999);

        // Clear five cycles after an ack aborts the conversion.
        grant(1'b1, 1'b0, 50, 0, g);
        wait_hold(4);
        do_clear();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("abort_valid", bcd_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_digits", digits, 16'h0000);
        end

        // Clear wins over a request in the same cycle.
        req_a = 1'b1;
        amt_a = 8'd5;
        do_clear();

        // Zero add keeps the digits stable throughout.
        for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 200, 0);
        add(1'b1, 1'b0, 34, 0);
        check("preload_1234", digits, 16'h1234);
        add(1'b1, 1'b0, 0, 0);
        check("zero_add", digits, 16'h1234);

        // Point the arbiter at B, then reset mid-conversion.
        grant(1'b1, 1'b1, 1, 1, g);
        check("pre_reset_grant_a", g, 0);
        finish_conv();
        grant(1'b1, 1'b0, 3, 0, g);
        wait_hold(6);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_idle_outputs("post_reset");
        end
        grant(1'b1, 1'b1, 7, 9, g);
        check("post_reset_rr", ack_a, 1);
        finish_conv();

        // Randomized traffic.
        do_clear();
        for (int n = 0; n < 40; n++) begin
            p = int'($urandom_range(1, 3));
            add(p[0], p[1], int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0) do_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
